f_npc_pc: RTL and testbench

Fetch-stage PC register and next-PC selector for the 5-stage MIPS pipeline. It consumes the D-stage comparator's branch decision (b_jump) plus the D-stage jump fields and forwarded rs value, and produces the PC and instruction-memory word address for F. MIPS delay-slot semantics apply: F always fetches D_pc+4 while D resolves control flow, and redirection takes effect on the following fetch. The block also keeps fetch/redirect statistics and a sticky fetch-address error flag.

---
 rtl/f_npc_pc.sv | 106 ++++++++++
 tb/tb_f_npc_pc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/f_npc_pc.sv
// Fetch-stage PC register with next-PC selection, fetch/redirect statistics
// and a sticky fetch-address error flag. Delay-slot semantics: the block
// never flushes; a redirect resolved in D lands on F_pc one cycle later.
module f_npc_pc #(
  parameter logic [31:0]  RESET_PC = 32'h0000_3000,
  parameter logic [31:0]  IM_BASE  = 32'h0000_3000,
  parameter int unsigned  IM_WORDS = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [2:0]                  npc_op,
  input  logic                        b_jump,
  input  logic [31:0]                 D_pc,
  input  logic [15:0]                 D_imm16,
  input  logic [25:0]                 D_instr_index,
  input  logic [31:0]                 D_rs_val,
  output logic [31:0]                 F_pc,
  output logic [$clog2(IM_WORDS)-1:0] im_addr,
  output logic [31:0]                 D_pc8,
  output logic                        addr_err,
  output logic [31:0]                 fetch_cnt,
  output logic [31:0]                 redirect_cnt
);

  localparam int unsigned AW     = $clog2(IM_WORDS);
  localparam logic [32:0] IM_END = 33'(IM_BASE) + 33'(IM_WORDS) * 33'd4;

  localparam logic [2:0] OP_PC4    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_J      = 3'd2;
  localparam logic [2:0] OP_JR     = 3'd3;

  logic [31:0] npc;
  logic        redirect;
  logic        npc_bad;
  logic [31:0] br_off;
  logic [3:0]  j_region;

  // Next-PC selection and redirect decision from the D-stage controls
  always_comb begin
    npc      = F_pc + 32'd4;
    redirect = 1'b0;
    br_off   = {{14{D_imm16[15]}}, D_imm16, 2'b00};
    j_region = 4'((D_pc + 32'd4) >> 28);
    case (npc_op)
      OP_PC4: begin
        npc = F_pc + 32'd4;
      end
      OP_BRANCH: begin
        if (b_jump) begin
          npc      = D_pc + 32'd4 + br_off;
          redirect = 1'b1;
        end
      end
      OP_J: begin
        npc      = {j_region, D_instr_index, 2'b00};
        redirect = 1'b1;
      end
      OP_JR: begin
        npc      = D_rs_val;
        redirect = 1'b1;
      end
      default: begin
        npc = F_pc + 32'd4;
      end
    endcase
  end

  // Misaligned or outside the instruction memory window
  always_comb begin
    npc_bad = (npc[1:0] != 2'b00) || (npc < IM_BASE) || ({1'b0, npc} >= IM_END);
  end

  // PC, statistics and sticky error update; stall freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc         <= RESET_PC;
      addr_err     <= 1'b0;
      fetch_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
    end else if (!stall) begin
      F_pc <= npc;
      if (npc_bad) begin
        addr_err <= 1'b1;
      end
      if (fetch_cnt != 32'hFFFF_FFFF) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (redirect && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end

  // Word index into instruction memory; out-of-range PCs wrap silently
  always_comb begin
    im_addr = AW'((F_pc - IM_BASE) >> 2);
  end

  // Link address for jal/jalr
  always_comb begin
    D_pc8 = D_pc + 32'd8;
  end

endmodule

// File: tb/tb_f_npc_pc.sv
// Randomized scoreboard bench for f_npc_pc: a driver applies one D-stage
// presentation per cycle and queues the expected post-edge state; a monitor
// pops and compares after every rising edge.
module tb_f_npc_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 4096;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic        b_jump;
  logic [31:0] D_pc;
  logic [15:0] D_imm16;
  logic [25:0] D_instr_index;
  logic [31:0] D_rs_val;
  logic [31:0] F_pc;
  logic [11:0] im_addr;
  logic [31:0] D_pc8;
  logic        addr_err;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  f_npc_pc #(.RESET_PC(RESET_PC), .IM_BASE(IM_BASE), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .b_jump(b_jump),
    .D_pc(D_pc), .D_imm16(D_imm16), .D_instr_index(D_instr_index),
    .D_rs_val(D_rs_val), .F_pc(F_pc), .im_addr(im_addr), .D_pc8(D_pc8),
    .addr_err(addr_err), .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [11:0] ia;
    logic [31:0] pc8;
    logic        err;
    logic [31:0] fc;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_id = 0;
  bit   stim_done = 0;

  // Reference architectural state
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_fc;
  logic [31:0] m_rc;

  function automatic logic [31:0] ref_npc(input logic [2:0] op, input logic bj,
                                          input logic [31:0] dpc, input logic [15:0] imm,
                                          input logic [25:0] idx, input logic [31:0] rs,
                                          input logic [31:0] pc);
    int off;
    off = int'($signed(imm)) * 4;
    if (op == 3'd1 && bj)  return dpc + 32'd4 + 32'(off);
    if (op == 3'd2)        return ((dpc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
    if (op == 3'd3)        return rs;
    return pc + 32'd4;
  endfunction

  function automatic bit ref_bad(input logic [31:0] a);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(IM_BASE);
    return (a % 4 != 0) || (la < lb) || (la - lb >= 64'(IM_WORDS) * 4);
  endfunction

  function automatic logic [11:0] ref_ia(input logic [31:0] pc);
    logic [31:0] w;
    w = (pc - IM_BASE) / 4;
    return 12'(w % IM_WORDS);
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected result
  task automatic cycle(input logic rst, input logic stl, input logic [2:0] op,
                       input logic bj, input logic [31:0] dpc, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs, input bit preload);
    exp_t e;
    logic [31:0] n;
    bit redir;
    @(negedge clk);
    reset = rst; stall = stl; npc_op = op; b_jump = bj;
    D_pc = dpc; D_imm16 = imm; D_instr_index = idx; D_rs_val = rs;
    if (preload) begin
      force dut.fetch_cnt = 32'hFFFF_FFFE;
      #1 release dut.fetch_cnt;
      m_fc = 32'hFFFF_FFFE;
    end
    if (rst) begin
      m_pc = RESET_PC; m_err = 1'b0; m_fc = 32'd0; m_rc = 32'd0;
    end else if (!stl) begin
      n     = ref_npc(op, bj, dpc, imm, idx, rs, m_pc);
      redir = (op == 3'd2) || (op == 3'd3) || (op == 3'd1 && bj);
      if (ref_bad(n)) m_err = 1'b1;
      m_pc = n;
      if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      if (redir && m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
    end
    e.id = cyc_id; e.pc = m_pc; e.ia = ref_ia(m_pc); e.pc8 = dpc + 32'd8;
    e.err = m_err; e.fc = m_fc; e.rc = m_rc;
    exp_q.push_back(e);
    cyc_id++;
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL cyc%0d %s actual=%h required=%h", id, nm, act, req);
    end
  endtask

  // Monitor: compare DUT state one step after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "F_pc", F_pc, e.pc);
        chk(e.id, "im_addr", 32'(im_addr), 32'(e.ia));
        chk(e.id, "D_pc8", D_pc8, e.pc8);
        chk(e.id, "addr_err", 32'(addr_err), 32'(e.err));
        chk(e.id, "fetch_cnt", fetch_cnt, e.fc);
        chk(e.id, "redirect_cnt", redirect_cnt, e.rc);
      end
    end
  end

  // Stimulus: directed scenarios then randomized traffic
  initial begin
    logic [2:0]  op;
    logic [31:0] dpc, rs;
    int          wait_cyc;
    reset = 1'b1; stall = 1'b0; npc_op = 3'd0; b_jump = 1'b0;
    D_pc = 32'd0; D_imm16 = 16'd0; D_instr_index = 26'd0; D_rs_val = 32'd0;
    m_pc = 32'd0; m_err = 1'b0; m_fc = 32'd0; m_rc = 32'd0;

    cycle(1, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);
    repeat (3) cycle(0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);
    // Taken branch backwards, then not-taken
    cycle(0, 0, 3'd1, 1, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 0);
    cycle(0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);
    cycle(0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);
    cycle(0, 0, 3'd1, 0, 32'h3008, 16'hFFFE, 26'h0, 32'h0, 0);
    // J into region of D_pc+4
    cycle(0, 0, 3'd2, 0, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 0);
    // JR to misaligned address: sticky error
    cycle(0, 0, 3'd3, 0, 32'h3010, 16'h0, 26'h0, 32'h3002, 0);
    cycle(0, 0, 3'd0, 0, 32'h3010, 16'h0, 26'h0, 32'h0, 0);
    cycle(0, 0, 3'd3, 0, 32'h3010, 16'h0, 26'h0, 32'h3100, 0);
    // Undefined op behaves as PC4
    cycle(0, 0, 3'd6, 1, 32'h3010, 16'h0, 26'h0, 32'h0, 0);
    // Stall holds J for two cycles then applies it once
    repeat (2) cycle(0, 1, 3'd2, 0, 32'h3020, 16'h0, 26'h0000D00, 32'h0, 0);
    cycle(0, 0, 3'd2, 0, 32'h3020, 16'h0, 26'h0000D00, 32'h0, 0);
    // Reset wins over stall and JR
    cycle(1, 1, 3'd3, 0, 32'h3020, 16'h0, 26'h0, 32'h5555, 0);
    // Fetch counter saturation
    cycle(0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 1);
    cycle(0, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);
    cycle(0, 1, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);
    cycle(0, 0, 3'd2, 0, 32'h3000, 16'h0, 26'h0000C00, 32'h0, 0);
    cycle(1, 0, 3'd0, 0, 32'h3000, 16'h0, 26'h0, 32'h0, 0);

    for (int i = 0; i < 400; i++) begin
      op  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) op = 3'd1;
      dpc = ($urandom_range(0, 9) == 0) ? $urandom : IM_BASE + 32'($urandom_range(0, IM_WORDS - 1)) * 4;
      rs  = ($urandom_range(0, 3) == 0) ? $urandom : IM_BASE + 32'($urandom_range(0, IM_WORDS - 1)) * 4;
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), op,
            1'($urandom_range(0, 1)), dpc, 16'($urandom), 26'($urandom), rs, 0);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    stim_done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
